dpd_adapt_sched: RTL

Round-robin scheduler that shares the single DPD feedback path (feedback mux, GVA gain switch controller, coefficient estimator) among N_CH transmit channels. It raises per-channel adaptation requests from a free-running period timer or software force pulses, then runs one adaptation cycle at a time: mux select, settle, capture window, estimation with timeout, and a guard gap. Its `adapt_req` output drives the GVA controller's `adapt_in`, whose rising edge starts the gain-switch capture sequence.

---
 rtl/dpd_adapt_sched.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/dpd_adapt_sched.sv
// dpd_adapt_sched: shares one DPD feedback path among N_CH transmit channels.
// Requests come from a free-running period timer or from force pulses. Channels
// are served one at a time in round-robin order. Each service runs mux select,
// settle, capture (adapt_req high), estimation with timeout, then a guard gap.
module dpd_adapt_sched #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PERIOD   = 10000000,
  parameter int unsigned SETTLE   = 64,
  parameter int unsigned CAPT_LEN = 6750,
  parameter int unsigned TIMEOUT  = 2000000,
  parameter int unsigned GUARD    = 256,
  localparam int unsigned SEL_W   = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [N_CH-1:0]  force_req,
  input  logic             est_done,
  output logic [SEL_W-1:0] fb_sel,
  output logic             adapt_req,
  output logic             est_start,
  output logic [N_CH-1:0]  ch_done,
  output logic [N_CH-1:0]  ch_timeout,
  output logic [7:0]       to_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_ESTIMATE = 3'd3,
    ST_GUARD    = 3'd4
  } state_t;

  // Terminal counts of the shared state timer and the period counter.
  localparam logic [31:0] PERIOD_LAST = PERIOD - 32'd1;
  localparam logic [31:0] SETTLE_LAST = SETTLE - 32'd1;
  localparam logic [31:0] CAPT_LAST   = CAPT_LEN - 32'd1;
  localparam logic [31:0] TMO_LAST    = TIMEOUT - 32'd1;
  localparam logic [31:0] GUARD_LAST  = GUARD - 32'd1;
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_CH - 1);

  // One-hot decode of a channel index.
  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = {{(N_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [31:0]        tmr_r, tmr_nxt_s;
  logic [31:0]        per_cnt_r;
  logic               tick_s;
  logic [N_CH-1:0]    pend_r, pend_nxt_s, elig_s, set_s, clr_s;
  logic [SEL_W-1:0]   ptr_r, grant_idx_s, idx_v;
  logic               found_s, grant_s, done_evt_s, tmo_evt_s, sel_en_s;

  logic [SEL_W-1:0]   fb_sel_r;
  logic               adapt_req_r, est_start_r, busy_r;
  logic [N_CH-1:0]    ch_done_r, ch_timeout_r;
  logic [7:0]         to_cnt_r;

  assign tick_s   = (per_cnt_r == PERIOD_LAST);
  assign elig_s   = pend_r & ch_en;
  assign sel_en_s = ch_en[fb_sel_r];

  // Free-running adaptation period counter.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      per_cnt_r <= 32'd0;
    end else if (tick_s) begin
      per_cnt_r <= 32'd0;
    end else begin
      per_cnt_r <= per_cnt_r + 32'd1;
    end
  end

  // Round-robin search: the reverse loop leaves the first eligible channel after ptr_r.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = ptr_r;
    idx_v       = ptr_r;
    for (int k = int'(N_CH); k >= 1; k--) begin
      int j;
      j = int'(ptr_r) + k;
      if (j >= int'(N_CH)) begin
        j = j - int'(N_CH);
      end else begin
        j = j;
      end
      idx_v = SEL_W'(j);
      if (elig_s[idx_v]) begin
        found_s     = 1'b1;
        grant_idx_s = idx_v;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Pending request update; a new request in the grant cycle survives the clear.
  always_comb begin
    set_s = ({N_CH{tick_s}} | force_req) & ch_en;
    if (grant_s) begin
      clr_s = onehot(grant_idx_s);
    end else begin
      clr_s = {N_CH{1'b0}};
    end
    pend_nxt_s = (set_s | (pend_r & ~clr_s)) & ch_en;
  end

  // Sequencer next-state and event decode.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    done_evt_s  = 1'b0;
    tmo_evt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          grant_s     = 1'b1;
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!sel_en_s) begin
          state_nxt_s = ST_GUARD;
        end else if (tmr_r == SETTLE_LAST) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        if (!sel_en_s) begin
          state_nxt_s = ST_GUARD;
        end else if (tmr_r == CAPT_LAST) begin
          state_nxt_s = ST_ESTIMATE;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_ESTIMATE: begin
        if (!sel_en_s) begin
          state_nxt_s = ST_GUARD;
        end else if (est_done) begin
          done_evt_s  = 1'b1;
          state_nxt_s = ST_GUARD;
        end else if (tmr_r == TMO_LAST) begin
          tmo_evt_s   = 1'b1;
          state_nxt_s = ST_GUARD;
        end else begin
          state_nxt_s = ST_ESTIMATE;
        end
      end
      ST_GUARD: begin
        if (tmr_r == GUARD_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GUARD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (state_nxt_s != state_r) begin
      tmr_nxt_s = 32'd0;
    end else begin
      tmr_nxt_s = tmr_r + 32'd1;
    end
  end

  // State, timer, pending bits and round-robin pointer.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= ST_IDLE;
      tmr_r   <= 32'd0;
      pend_r  <= {N_CH{1'b0}};
      ptr_r   <= PTR_RST;
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
      pend_r  <= pend_nxt_s;
      if (grant_s) begin
        ptr_r <= grant_idx_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Registered outputs decoded from the next state and this cycle's events.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      fb_sel_r     <= {SEL_W{1'b0}};
      adapt_req_r  <= 1'b0;
      est_start_r  <= 1'b0;
      ch_done_r    <= {N_CH{1'b0}};
      ch_timeout_r <= {N_CH{1'b0}};
      to_cnt_r     <= 8'd0;
      busy_r       <= 1'b0;
    end else begin
      if (grant_s) begin
        fb_sel_r <= grant_idx_s;
      end else begin
        fb_sel_r <= fb_sel_r;
      end
      adapt_req_r  <= (state_nxt_s == ST_CAPTURE);
      est_start_r  <= (state_r == ST_CAPTURE) && (state_nxt_s == ST_ESTIMATE);
      ch_done_r    <= done_evt_s ? onehot(fb_sel_r) : {N_CH{1'b0}};
      ch_timeout_r <= tmo_evt_s ? onehot(fb_sel_r) : {N_CH{1'b0}};
      if (tmo_evt_s && (to_cnt_r != 8'hFF)) begin
        to_cnt_r <= to_cnt_r + 8'd1;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign fb_sel     = fb_sel_r;
  assign adapt_req  = adapt_req_r;
  assign est_start  = est_start_r;
  assign ch_done    = ch_done_r;
  assign ch_timeout = ch_timeout_r;
  assign to_cnt     = to_cnt_r;
  assign busy       = busy_r;

endmodule
